// File: rtl/output_port_allocator.sv
// ---------------------------------------------------------------------------
// output_port_allocator
//
// Switch allocator for one router output port. The input units whose route
// computation selected this port raise i_req. The allocator picks one of them
// round-robin and locks the port to it (wormhole switching). The lock is held
// until that input's tail flit crosses the switch, or until the input withdraws
// its request (abort). The port then spends at least one cycle idle before it
// grants again.
//
// Ports:
//   clk          router clock
//   reset        synchronous, active-high reset
//   i_req        per-input switch request, already filtered to this port
//   i_valid      per-input "flit presented is valid"
//   i_tail       per-input "flit presented is a tail" (qualified by i_valid)
//   i_out_ready  downstream link can take a flit this cycle
//   o_grant      one-hot switch ack to the input units, zero when unlocked
//   o_grant_idx  crossbar select (index of the granted input)
//   o_busy       port is locked to a packet
//   o_xfer       a flit crosses the switch this cycle
//   o_stall_err  one-cycle pulse when a lock goes MAX_STALL cycles without a
//                transfer (diagnostic only; the lock is kept)
//   o_pkt_cnt    number of completed packets, wraps at 16 bits
// ---------------------------------------------------------------------------
module output_port_allocator #(
    parameter int NUM_INPUTS = 5,
    parameter int IDX_W      = $clog2(NUM_INPUTS),
    parameter int MAX_STALL  = 64,
    parameter int STALL_W    = $clog2(MAX_STALL + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [NUM_INPUTS-1:0] i_valid,
    input  logic [NUM_INPUTS-1:0] i_tail,
    input  logic                  i_out_ready,
    output logic [NUM_INPUTS-1:0] o_grant,
    output logic [IDX_W-1:0]      o_grant_idx,
    output logic                  o_busy,
    output logic                  o_xfer,
    output logic                  o_stall_err,
    output logic [15:0]           o_pkt_cnt
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(MAX_STALL);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]            state_q,     state_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [NUM_INPUTS-1:0] grant_q,     grant_d;
    logic [IDX_W-1:0]      ptr_q,       ptr_d;
    logic [STALL_W-1:0]    stall_q,     stall_d;
    logic [15:0]           pkt_cnt_q,   pkt_cnt_d;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after the pointer, wrapping.
    // Requests at or above the pointer are tried first; if there are none,
    // the lowest-numbered requester overall is the wrap-around choice.
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] at_or_after_ptr;
    logic [NUM_INPUTS-1:0] req_hi;
    logic [NUM_INPUTS-1:0] pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  any_req;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_mask
        assign at_or_after_ptr[gi] = (IDX_W'(gi) >= ptr_q);
    end

    assign req_hi  = i_req & at_or_after_ptr;
    assign any_req = |i_req;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_INPUTS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        // Scanning downward leaves the lowest set bit as the final winner.
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = IDX_W'(k);
            end
        end
        return r;
    endfunction

    assign pick_idx = (|req_hi) ? lowest_set(req_hi) : lowest_set(i_req);

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end

    // ------------------------------------------------------------------
    // Signals of the currently granted input
    // ------------------------------------------------------------------
    logic locked;
    logic cur_req;
    logic cur_valid;
    logic cur_tail;
    logic xfer;
    logic tail_release;
    logic release_now;
    logic [IDX_W-1:0] ptr_after;

    assign locked       = (state_q == ST_LOCKED);
    assign cur_req      = i_req[grant_idx_q];
    assign cur_valid    = i_valid[grant_idx_q];
    assign cur_tail     = i_tail[grant_idx_q];
    assign xfer         = locked & cur_valid & i_out_ready;
    assign tail_release = xfer & cur_tail;
    // A tail transfer in the same cycle as a dropped request is still a normal
    // end of packet; tail_release wins when deciding whether to count it.
    assign release_now  = locked & (tail_release | ~cur_req);

    // Pointer moves just past the input that held the port, so it goes to the
    // back of the line.
    assign ptr_after = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        stall_d     = stall_q;
        pkt_cnt_d   = pkt_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_LOCKED;
                    grant_idx_d = pick_idx;
                    grant_d     = pick_onehot;
                    stall_d     = '0;
                end
            end

            ST_LOCKED: begin
                // Watchdog: cleared by any transfer, otherwise counts up and
                // sticks at the limit so the error pulse fires only once.
                if (xfer) begin
                    stall_d = '0;
                end else if (stall_q != STALL_MAX) begin
                    stall_d = stall_q + STALL_W'(1);
                end

                // Releasing always lands in IDLE, which guarantees a one-cycle
                // gap before the next grant.
                if (release_now) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                    stall_d = '0;
                    if (tail_release) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                stall_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers with synchronous reset. Reset mid-packet simply drops the
    // lock; no release bookkeeping happens.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            stall_q     <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            stall_q     <= stall_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Grant and crossbar select come straight from flops.
    // ------------------------------------------------------------------
    assign o_grant     = grant_q;
    assign o_grant_idx = grant_idx_q;
    assign o_busy      = locked;
    assign o_xfer      = xfer;
    // The pulse lands on the stalled cycle that takes the count to the limit.
    assign o_stall_err = locked & ~xfer & (stall_q == STALL_LAST);
    assign o_pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// ---------------------------------------------------------------------------
// Testbench for output_port_allocator (NUM_INPUTS=5, MAX_STALL=4).
// A cycle-level reference model of the port (locked flag, owner, pointer,
// consecutive-stall count, packet count) predicts every output every cycle.
// Directed scenarios come first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_output_port_allocator;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  i_req;
    logic [N-1:0]  i_valid;
    logic [N-1:0]  i_tail;
    logic          i_out_ready;
    logic [N-1:0]  o_grant;
    logic [IW-1:0] o_grant_idx;
    logic          o_busy;
    logic          o_xfer;
    logic          o_stall_err;
    logic [15:0]   o_pkt_cnt;

    always #5 clk = ~clk;

    output_port_allocator #(
        .NUM_INPUTS (N),
        .MAX_STALL  (MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_valid     (i_valid),
        .i_tail      (i_tail),
        .i_out_ready (i_out_ready),
        .o_grant     (o_grant),
        .o_grant_idx (o_grant_idx),
        .o_busy      (o_busy),
        .o_xfer      (o_xfer),
        .o_stall_err (o_stall_err),
        .o_pkt_cnt   (o_pkt_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_locked = 1'b0;
    int m_g      = 0;
    int m_ptr    = 0;
    int m_stall  = 0;
    int m_pkts   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare all outputs against the model,
    // advance the model, move to the next falling edge.
    task automatic tick(input logic rst, input logic [N-1:0] req,
                        input logic [N-1:0] valid, input logic [N-1:0] tail,
                        input logic rdy);
        bit exp_xfer;
        bit tail_end;
        reset       = rst;
        i_req       = req;
        i_valid     = valid;
        i_tail      = tail;
        i_out_ready = rdy;
        #1;
        exp_xfer = m_locked && valid[m_g] && rdy;
        chk("grant", 32'(o_grant), m_locked ? (32'd1 << m_g) : 32'd0);
        chk("busy", 32'(o_busy), 32'(m_locked));
        if (m_locked) chk("grant_idx", 32'(o_grant_idx), 32'(m_g));
        chk("xfer", 32'(o_xfer), 32'(exp_xfer));
        chk("stall_err", 32'(o_stall_err), 32'(m_locked && !exp_xfer && (m_stall + 1 == MS)));
        chk("pkt_cnt", 32'(o_pkt_cnt), 32'(m_pkts));

        if (rst) begin
            m_locked = 1'b0;
            m_g      = 0;
            m_ptr    = 0;
            m_stall  = 0;
            m_pkts   = 0;
        end else if (!m_locked) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (req[c]) begin
                        m_g = c;
                        break;
                    end
                end
                m_locked = 1'b1;
                m_stall  = 0;
            end
        end else begin
            if (exp_xfer) m_stall = 0;
            else          m_stall = m_stall + 1;
            tail_end = exp_xfer && tail[m_g];
            if (tail_end || !req[m_g]) begin
                if (tail_end) m_pkts = (m_pkts + 1) % 65536;
                m_ptr    = (m_g + 1) % N;
                m_locked = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    logic [IW-1:0] order[$];
    int            exp_order[6] = '{0, 1, 2, 3, 4, 0};
    logic [15:0]   saved_cnt;
    logic [N-1:0]  r_req;
    logic [N-1:0]  r_valid;
    logic [N-1:0]  r_tail;
    logic          r_rdy;
    logic          r_rst;

    initial begin
        reset = 1'b1; i_req = '0; i_valid = '0; i_tail = '0; i_out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        tick(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        tick(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("rst_idx", 32'(o_grant_idx), 32'd0);

        // Single requester, 3-flit packet
        tick(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        chk("sp_grant", 32'(o_grant), 32'(5'b00100));
        chk("sp_idx", 32'(o_grant_idx), 32'd2);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1);
        chk("sp_cnt", 32'(o_pkt_cnt), 32'd1);
        chk("sp_idle", 32'(o_busy), 32'd0);
        tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);

        // Round-robin fairness from a fresh pointer
        tick(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 5'b11111, 5'b11111, 5'b11111, 1'b1);
            if (o_busy) order.push_back(o_grant_idx);
        end
        chk("rr_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
        end

        // Backpressure on input 1 (also exercises the stall pulse)
        tick(1'b0, 5'b00010, 5'b00000, 5'b00000, 1'b0);
        for (int c = 0; c < 10; c++) tick(1'b0, 5'b00010, 5'b00010, 5'b00000, 1'b0);
        chk("bp_held", 32'(o_grant), 32'(5'b00010));
        tick(1'b0, 5'b00010, 5'b00010, 5'b00010, 1'b1);
        tick(1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1);
        chk("bp_ptr", 32'(o_grant_idx), 32'd2);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1);

        // Abort from input 3 with input 0 pending
        tick(1'b0, 5'b01001, 5'b00000, 5'b00000, 1'b1);
        chk("ab_lock3", 32'(o_grant_idx), 32'd3);
        saved_cnt = o_pkt_cnt;
        tick(1'b0, 5'b00001, 5'b00000, 5'b00000, 1'b1);
        chk("ab_idle", 32'(o_busy), 32'd0);
        tick(1'b0, 5'b00001, 5'b00000, 5'b00000, 1'b1);
        chk("ab_next0", 32'(o_grant_idx), 32'd0);
        chk("ab_cnt", 32'(o_pkt_cnt), 32'(saved_cnt));
        tick(1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b1);

        // Stall watchdog: pulse once, clear on transfer, pulse again later
        tick(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        for (int c = 0; c < 6; c++) tick(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1);
        for (int c = 0; c < 5; c++) tick(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1);

        // Reset mid-packet on input 2
        tick(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1);
        tick(1'b1, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        chk("mr_grant", 32'(o_grant), 32'd0);
        chk("mr_cnt", 32'(o_pkt_cnt), 32'd0);
        tick(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        chk("mr_regrant", 32'(o_grant_idx), 32'd2);
        tick(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1);

        // Randomized traffic against the model
        r_req = '0;
        for (int c = 0; c < 600; c++) begin
            r_req   = r_req ^ (N'($urandom) & N'($urandom) & N'($urandom));
            r_valid = N'($urandom);
            r_tail  = N'($urandom) & N'($urandom);
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_rst   = ($urandom_range(0, 99) == 0);
            tick(r_rst, r_req, r_valid, r_tail, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port switch arbiter for the router. One instance sits on each output port.
- Collects switch requests from the input-unit FSMs whose computed route targets this port and grants the port to one input using round-robin.
- Holds the grant (wormhole lock) until that input's tail flit transfers, then releases.
- Drives the per-input switch-ack and the crossbar select for this port.

Parameters:
NUM_INPUTS, 5, number of requesting input units (router ports)
IDX_W, $clog2(NUM_INPUTS), width of grant index
MAX_STALL, 64, consecutive locked cycles without a transfer before the stall flag fires
STALL_W, $clog2(MAX_STALL+1), width of stall counter

Ports:
clk  input  1  router clock
reset  input  1  synchronous, active-high reset
i_req  input  NUM_INPUTS  switch request per input, already filtered to inputs routed to this port
i_valid  input  NUM_INPUTS  flit presented by input k is valid
i_tail  input  NUM_INPUTS  flit presented by input k is a tail flit (qualified by i_valid)
i_out_ready  input  1  downstream/link can accept a flit this cycle
o_grant  output  NUM_INPUTS  one-hot switch ack to the input units, zero when unlocked
o_grant_idx  output  IDX_W  crossbar select, index of the granted input
o_busy  output  1  port locked to a packet
o_xfer  output  1  flit transfer this cycle
o_stall_err  output  1  one-cycle pulse when a lock stalls MAX_STALL cycles
o_pkt_cnt  output  16  packets completed, wrapping counter

Behaviour:
- Reset (synchronous, on clk with reset=1):
  - o_grant=0, o_grant_idx=0, o_busy=0, o_xfer=0, o_stall_err=0, o_pkt_cnt=0.
  - Round-robin pointer=0, stall counter=0, state=IDLE.
  - A reset asserted mid-packet drops the lock immediately. No release bookkeeping and no counter increment.
- States:
  - IDLE: no lock.
    - If any i_req bit is set, pick the first requester at or after the pointer, cyclically. Latch its index into the grant register and go to LOCKED.
    - Otherwise stay in IDLE.
  - LOCKED: o_grant=onehot(grant_idx), o_busy=1.
- Grant latency:
  - A request sampled in IDLE at edge t gives o_grant at edge t+1. This is one cycle, registered.
  - o_grant and o_grant_idx are driven from flops only.
- Transfer (combinational in LOCKED):
  - o_xfer = i_valid[g] & i_out_ready, where g = grant_idx.
  - o_xfer is 0 in IDLE.
- Release (LOCKED to IDLE) when either holds:
  - o_xfer & i_tail[g] — normal end of packet. o_pkt_cnt increments by 1, wrapping 0xFFFF to 0.
  - ~i_req[g] — abort. No count increment.
  - Tail and abort in the same cycle count as a normal release.
  - On any release the pointer becomes (g+1) mod NUM_INPUTS.
- No back-to-back grants: after a release, the port spends at least one cycle in IDLE, so the minimum packet-to-packet gap is 1 cycle.
- Requests from other inputs while LOCKED are ignored and not queued. Requesters keep i_req high until granted.
- Single-flit packet (head with tail set): a grant followed by one o_xfer releases in that same cycle.
- Stall counter:
  - Cleared on entry to LOCKED and on every o_xfer cycle.
  - Otherwise increments while LOCKED, saturating at MAX_STALL.
  - o_stall_err pulses for exactly the cycle the counter reaches MAX_STALL.
  - The grant is kept; this is diagnostics only.
- i_tail and i_valid of non-granted inputs are don't-care.

Test Plan:
- Reset mid-packet: lock input 2, assert reset 1 cycle -> next cycle o_grant=0, o_busy=0, o_pkt_cnt=0, pointer=0, and a new request from input 2 is granted 1 cycle later.
- Single requester, 3-flit packet: i_req=5'b00100 at cycle 0 -> o_grant=5'b00100, o_grant_idx=2 at cycle 1. Three valid flits with ready, tail on the 3rd -> o_xfer high 3 cycles, release, o_pkt_cnt=1, IDLE for 1 cycle.
- Round-robin fairness: i_req=5'b11111 held with 1-flit packets each -> grant order 0,1,2,3,4,0, with exactly one IDLE cycle between grants.
- Backpressure: locked to input 1, i_valid=1, i_out_ready=0 for 10 cycles -> o_xfer=0 and grant held. Ready returns with a tail -> release, pointer=2.
- Abort: locked to input 3, i_req[3] drops with no tail -> next cycle IDLE, o_pkt_cnt unchanged, pointer=4, pending input 0 is granted next.
- Stall watchdog, MAX_STALL=4: locked with i_valid=0 -> o_stall_err pulses once on the 4th stalled cycle and does not repeat. A subsequent transfer clears the counter.
